// File: rtl/bcorrect_queue_pkg.sv
// bcorrect_queue_pkg: default widths, i_data field offsets and redirect record type
package bcorrect_queue_pkg;
  localparam int PC_W_DEF = 32;
  localparam int POS_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 3;
  localparam int THRESH_DEF = 4;
  function automatic int pos_lsb();
    return 0;
  endfunction
  function automatic int pc_lsb(int pos_w);
    return pos_w;
  endfunction
  function automatic int mis_bit(int pc_w, int pos_w);
    return pc_w + pos_w;
  endfunction
  function automatic int vld_bit(int pc_w, int pos_w);
    return pc_w + pos_w + 1;
  endfunction
  localparam int POS_LSB = pos_lsb();
  localparam int PC_LSB = pc_lsb(POS_W_DEF);
  localparam int MIS_BIT = mis_bit(PC_W_DEF, POS_W_DEF);
  localparam int VLD_BIT = vld_bit(PC_W_DEF, POS_W_DEF);
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [POS_W_DEF-1:0] pos;
  } redir_t;
endpackage

// File: rtl/bcorrect_queue_if.sv
// bcorrect_queue_if: resolve-record input, flush and redirect handshake bundle
interface bcorrect_queue_if #(
  parameter int PC_W = 32,
  parameter int POS_W = 8,
  parameter int CNT_W = 3
);
  logic [PC_W+POS_W+1:0] i_data;
  logic i_flush;
  logic o_in_ready;
  logic o_redir_valid;
  logic i_redir_ready;
  logic [PC_W-1:0] o_correctpc;
  logic [POS_W-1:0] o_errPos;
  logic [CNT_W-1:0] o_counter;
  logic o_storm;
  logic o_overflow;
  modport slave (
    input i_data, i_flush, i_redir_ready,
    output o_in_ready, o_redir_valid, o_correctpc, o_errPos, o_counter, o_storm, o_overflow
  );
  modport master (
    output i_data, i_flush, i_redir_ready,
    input o_in_ready, o_redir_valid, o_correctpc, o_errPos, o_counter, o_storm, o_overflow
  );
endinterface

// File: rtl/bcorrect_queue_fifo.sv
// bcorrect_queue_fifo: DEPTH x W synchronous FIFO with flush, head reads as zero when empty
module bcorrect_queue_fifo #(
  parameter int W = 40,
  parameter int DEPTH = 4
) (
  input  logic         fire,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
  // Pointer advance and slot write; flush overrides any concurrent push or pop
  always_comb begin
    mem_d = mem_q;
    wr_d = flush ? '0 : wr_q + {{AW{1'b0}}, push};
    rd_d = flush ? '0 : rd_q + {{AW{1'b0}}, pop};
    if (push && !flush) mem_d[wr_q[AW-1:0]] = din;
  end
  // State register, cleared asynchronously so no stale entry survives reset
  always_ff @(posedge fire or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/bcorrect_queue.sv
// bcorrect_queue: mispredict counter, storm/overflow flags and redirect FIFO handshake glue
module bcorrect_queue
  import bcorrect_queue_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int POS_W = POS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input logic fire,
  input logic rst,
  bcorrect_queue_if.slave bus
);
  localparam int W = PC_W + POS_W;
  localparam int VB = vld_bit(PC_W, POS_W);
  localparam int MB = mis_bit(PC_W, POS_W);
  logic vld, mis, push_req, pop, in_ready, full, empty;
  logic [W-1:0] head;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic overflow_q, overflow_d;
  assign vld = bus.i_data[VB];
  assign mis = bus.i_data[MB];
  assign push_req = vld & mis;
  assign pop = !empty & bus.i_redir_ready;
  assign in_ready = !full | pop;
  bcorrect_queue_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .fire(fire),
    .rst(rst),
    .push(push_req & in_ready),
    .pop(pop),
    .flush(bus.i_flush),
    .din(bus.i_data[W-1:0]),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign bus.o_in_ready = in_ready;
  assign bus.o_redir_valid = !empty;
  assign bus.o_correctpc = head[W-1:POS_W];
  assign bus.o_errPos = head[POS_W-1:0];
  assign bus.o_counter = counter_q;
  assign bus.o_storm = counter_q >= CNT_W'(THRESH);
  assign bus.o_overflow = overflow_q;
  // Saturating mispredict streak and sticky drop flag, both cleared by flush
  always_comb begin
    counter_d = !vld ? counter_q : !mis ? '0 : (&counter_q) ? counter_q : counter_q + 1'b1;
    overflow_d = overflow_q | (push_req & !in_ready);
    if (bus.i_flush) begin
      counter_d = '0;
      overflow_d = 1'b0;
    end
  end
  // Counter and overflow registers
  always_ff @(posedge fire or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      overflow_q <= overflow_d;
    end
  end
endmodule
